and_tree_resp_monitor: RTL and testbench

- Clocked checker that consumes the output of a co-simulated AND-tree netlist (the prsim-driven z) together with the same leaf inputs the bench drives into it.
- Synchronizes the asynchronous z, computes the expected AND of the inputs, and measures response latency in cycles.
- Flags timeouts and glitches, and counts output transitions.
- Sits directly downstream of the prsim AND tree in the mixed Verilog/prsim bench.

---
 rtl/and_tree_resp_monitor.sv | 121 ++++++++++++
 tb/tb_and_tree_resp_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/and_tree_resp_monitor.sv
// and_tree_resp_monitor: checks a prsim AND-tree output against the AND of its leaves, timing responses and flagging faults.
// Optional max_lat output enabled by defining AND_TREE_MON_MAXLAT_EN.
module and_tree_resp_monitor #(
    parameter int N_IN        = 4,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             z_async,
    output logic             exp_z,
    output logic             busy,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             timeout_err,
    output logic             glitch_err
`ifdef AND_TREE_MON_MAXLAT_EN
    ,
    output logic [CNT_W-1:0] max_lat
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLED, PENDING, FAULT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       lat_cnt;
    logic                   z_s, z_prev, exp_next, exp_chg, match, rise, fall;
    logic [CNT_W-1:0]       lat_nxt;
    assign z_s      = sync[SYNC_STAGES-1];
    assign exp_next = &in_vec;
    assign exp_chg  = exp_next != exp_z;
    assign match    = z_s == exp_z;
    assign rise     = z_s & ~z_prev;
    assign fall     = ~z_s & z_prev;
    assign lat_nxt  = lat_cnt + 1'b1;
    assign busy     = state == PENDING;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync        <= '0;
            z_prev      <= 1'b0;
            exp_z       <= 1'b0;
            lat_cnt     <= '0;
            last_lat    <= '0;
            rise_cnt    <= '0;
            fall_cnt    <= '0;
            timeout_err <= 1'b0;
            glitch_err  <= 1'b0;
`ifdef AND_TREE_MON_MAXLAT_EN
            max_lat     <= '0;
`endif
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], z_async};
            z_prev <= z_s;
            exp_z  <= exp_next;
            if (!enable) begin
                state <= IDLE;
            end else if (clear) begin
                rise_cnt    <= '0;
                fall_cnt    <= '0;
                last_lat    <= '0;
                timeout_err <= 1'b0;
                glitch_err  <= 1'b0;
`ifdef AND_TREE_MON_MAXLAT_EN
                max_lat     <= '0;
`endif
                state       <= match ? SETTLED : PENDING;
                lat_cnt     <= '0;
            end else begin
                if (rise && rise_cnt != CNT_MAX) rise_cnt <= rise_cnt + 1'b1;
                if (fall && fall_cnt != CNT_MAX) fall_cnt <= fall_cnt + 1'b1;
                case (state)
                    IDLE: begin
                        state   <= match ? SETTLED : PENDING;
                        lat_cnt <= '0;
                    end
                    SETTLED: begin
                        if (exp_chg) begin
                            state   <= PENDING;
                            lat_cnt <= '0;
                        end else if (!match) begin
                            glitch_err <= 1'b1;
                            state      <= FAULT;
                        end
                    end
                    PENDING: begin
                        // an input change restarts the measurement rather than counting as an error
                        if (exp_chg) begin
                            lat_cnt <= '0;
                        end else if (match) begin
                            last_lat <= lat_nxt;
`ifdef AND_TREE_MON_MAXLAT_EN
                            if (lat_nxt > max_lat) max_lat <= lat_nxt;
`endif
                            state    <= SETTLED;
                        end else if (lat_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= FAULT;
                        end else if (lat_cnt != CNT_MAX) begin
                            lat_cnt <= lat_nxt;
                        end
                    end
                    default: begin
                        if (exp_chg) begin
                            state   <= PENDING;
                            lat_cnt <= '0;
                        end else if (match) begin
                            state <= SETTLED;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_and_tree_resp_monitor.sv
// tb_and_tree_resp_monitor: directed and randomized checks of and_tree_resp_monitor against a cycle-indexed reference model.
module tb_and_tree_resp_monitor;
    localparam int N_IN = 4, TIMEOUT = 16, CNT_W = 8, SYNC = 2;
    localparam int M_IDLE = 0, M_SET = 1, M_PEND = 2, M_FAULT = 3;
    logic clk = 0, rst_n, enable, clear, z_async, exp_z, busy, timeout_err, glitch_err;
    logic [N_IN-1:0]  in_vec;
    logic [CNT_W-1:0] last_lat, rise_cnt, fall_cnt;
`ifdef AND_TREE_MON_MAXLAT_EN
    logic [CNT_W-1:0] max_lat;
`endif
    int n_cmp = 0, n_bad = 0;
    bit m_exp, m_zprev, m_to, m_gl;
    bit zq[$];
    int m_st, cyc, t_start;
    logic [CNT_W-1:0] m_last, m_rise, m_fall, m_max;

    and_tree_resp_monitor #(.N_IN(N_IN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .in_vec(in_vec), .z_async(z_async),
        .exp_z(exp_z), .busy(busy), .last_lat(last_lat), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
        .timeout_err(timeout_err), .glitch_err(glitch_err)
`ifdef AND_TREE_MON_MAXLAT_EN
        , .max_lat(max_lat)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_exp = 0; m_zprev = 0; m_to = 0; m_gl = 0; m_st = M_IDLE;
        m_last = 0; m_rise = 0; m_fall = 0; m_max = 0; t_start = cyc;
        zq.delete();
        for (int i = 0; i < SYNC; i++) zq.push_back(1'b0);
    endtask

    // z_s is the sample taken SYNC edges ago; latency is edges elapsed since the measurement began
    task automatic model_step();
        bit zs, exp_n, chg;
        int lat;
        zs = zq[0];
        exp_n = &in_vec;
        chg = exp_n != m_exp;
        lat = cyc - t_start;
        if (!enable) m_st = M_IDLE;
        else if (clear) begin
            m_rise = 0; m_fall = 0; m_last = 0; m_to = 0; m_gl = 0; m_max = 0;
            if (zs == m_exp) m_st = M_SET; else begin m_st = M_PEND; t_start = cyc + 1; end
        end else begin
            if (zs && !m_zprev && m_rise != 8'hFF) m_rise++;
            if (!zs && m_zprev && m_fall != 8'hFF) m_fall++;
            if (m_st == M_IDLE) begin
                if (zs == m_exp) m_st = M_SET; else begin m_st = M_PEND; t_start = cyc + 1; end
            end else if (m_st == M_PEND) begin
                if (chg) t_start = cyc + 1;
                else if (zs == m_exp) begin
                    m_last = CNT_W'(lat + 1);
                    if (m_last > m_max) m_max = m_last;
                    m_st = M_SET;
                end else if (lat == TIMEOUT - 1) begin m_to = 1; m_st = M_FAULT; end
            end else if (chg) begin
                m_st = M_PEND; t_start = cyc + 1;
            end else if (zs != m_exp) begin
                if (m_st == M_SET) begin m_gl = 1; m_st = M_FAULT; end
            end else m_st = M_SET;
        end
        m_zprev = zs;
        zq.push_back(z_async);
        void'(zq.pop_front());
        m_exp = exp_n;
        cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({exp_z, busy, timeout_err, glitch_err} !== 4'b0 || last_lat !== 0 || rise_cnt !== 0 || fall_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset flags=%b lat=%0d rise=%0d fall=%0d want all 0", {exp_z, busy, timeout_err, glitch_err}, last_lat, rise_cnt, fall_cnt);
        end
    endtask

    task automatic test_settle();
        rst_n = 1; enable = 1;
        repeat (20) tick();
        n_cmp++;
        if ({exp_z, busy, timeout_err, glitch_err} !== 4'b0 || rise_cnt !== 0 || fall_cnt !== 0) begin
            n_bad++;
            $display("FAIL settle flags=%b rise=%0d fall=%0d want 0", {exp_z, busy, timeout_err, glitch_err}, rise_cnt, fall_cnt);
        end
    endtask

    task automatic test_latency();
        int nb = 0;
        in_vec = 4'hF;
        for (int i = 0; i < 3; i++) begin tick(); nb += int'(busy); end
        z_async = 1;
        for (int i = 0; i < 20; i++) begin tick(); nb += int'(busy); end
        n_cmp++;
        if (nb != 5) begin n_bad++; $display("FAIL lat_busy got=%0d want=5", nb); end
        n_cmp++;
        if (last_lat !== 8'd5 || rise_cnt !== 8'd1) begin
            n_bad++; $display("FAIL lat_value last_lat=%0d rise=%0d want 5/1", last_lat, rise_cnt);
        end
        n_cmp++;
        if ({exp_z, timeout_err, glitch_err} !== 3'b100) begin
            n_bad++; $display("FAIL lat_flags got=%b want=100", {exp_z, timeout_err, glitch_err});
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        in_vec = 4'hE;
        while (n < 40 && timeout_err !== 1'b1) begin tick(); n++; end
        n_cmp++;
        if (n - 1 != 16) begin n_bad++; $display("FAIL timeout_delay got=%0d want=16", n - 1); end
        z_async = 0;
        repeat (5) tick();
        n_cmp++;
        if (last_lat !== 8'd5 || busy !== 1'b0 || glitch_err !== 1'b0 || m_st != M_SET) begin
            n_bad++; $display("FAIL timeout_recover last_lat=%0d busy=%b glitch=%b want 5/0/0", last_lat, busy, glitch_err);
        end
    endtask

    task automatic test_glitch();
        logic [CNT_W-1:0] r0, f0;
        in_vec = 4'hF; z_async = 1;
        repeat (6) tick();
        n_cmp++;
        if (last_lat !== 8'd2) begin n_bad++; $display("FAIL min_latency got=%0d want=2", last_lat); end
        r0 = rise_cnt; f0 = fall_cnt;
        z_async = 0;
        repeat (4) tick();
        z_async = 1;
        repeat (6) tick();
        n_cmp++;
        if (glitch_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL glitch_flag glitch=%b busy=%b want 1/0", glitch_err, busy);
        end
        n_cmp++;
        if (rise_cnt !== r0 + 8'd1 || fall_cnt !== f0 + 8'd1) begin
            n_bad++; $display("FAIL glitch_counts rise=%0d fall=%0d want %0d/%0d", rise_cnt, fall_cnt, r0 + 8'd1, f0 + 8'd1);
        end
        clear = 1; tick(); clear = 0;
        n_cmp++;
        if ({timeout_err, glitch_err} !== 2'b00 || last_lat !== 0 || rise_cnt !== 0) begin
            n_bad++; $display("FAIL clear_errs to=%b gl=%b lat=%0d rise=%0d want 0", timeout_err, glitch_err, last_lat, rise_cnt);
        end
    endtask

    task automatic test_toggle();
        z_async = 1;
        for (int i = 0; i < 10; i++) begin in_vec = ((i / 2) % 2 != 0) ? 4'hF : 4'hE; tick(); end
        in_vec = 4'hF;
        repeat (4) tick();
        n_cmp++;
        if ({timeout_err, glitch_err, busy} !== 3'b000) begin
            n_bad++; $display("FAIL toggle to/gl/busy=%b want 000", {timeout_err, glitch_err, busy});
        end
    endtask

    task automatic test_async_reset();
        in_vec = 4'hE;
        repeat (8) tick();
        n_cmp++;
        if (busy !== 1'b1 || cyc - t_start != 7) begin n_bad++; $display("FAIL pre_reset busy=%b want 1", busy); end
        #1 rst_n = 0;
        #1;
        n_cmp++;
        if ({exp_z, busy, timeout_err, glitch_err} !== 4'b0 || last_lat !== 0 || rise_cnt !== 0 || fall_cnt !== 0) begin
            n_bad++;
            $display("FAIL async_reset flags=%b lat=%0d rise=%0d fall=%0d want 0", {exp_z, busy, timeout_err, glitch_err}, last_lat, rise_cnt, fall_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0 || exp_z !== 1'b0) begin n_bad++; $display("FAIL post_reset busy=%b exp_z=%b want 0/0", busy, exp_z); end
    endtask

    task automatic test_clear_sat();
        in_vec = 4'h0;
        for (int i = 0; i < 540; i++) begin z_async = ~z_async; tick(); end
        n_cmp++;
        if (rise_cnt !== 8'hFF || fall_cnt !== 8'hFF) begin
            n_bad++; $display("FAIL saturate rise=%0d fall=%0d want 255/255", rise_cnt, fall_cnt);
        end
        z_async = ~z_async;
        clear = 1; tick(); clear = 0;
        n_cmp++;
        if (rise_cnt !== 0 || fall_cnt !== 0 || glitch_err !== 0) begin
            n_bad++; $display("FAIL clear_sat rise=%0d fall=%0d gl=%b want 0", rise_cnt, fall_cnt, glitch_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            enable = $urandom_range(0, 19) != 0;
            clear = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 5) == 0) in_vec = $urandom_range(0, 1) != 0 ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 3) == 0) z_async = &in_vec;
            else if ($urandom_range(0, 19) == 0) z_async = ~z_async;
            tick();
            n_cmp++;
            if (exp_z !== m_exp || busy !== (m_st == M_PEND)) begin
                n_bad++; $display("FAIL rnd_state cyc=%0d exp_z=%b busy=%b want %b/%b", cyc, exp_z, busy, m_exp, m_st == M_PEND);
            end
            n_cmp++;
            if (last_lat !== m_last) begin n_bad++; $display("FAIL rnd_last_lat cyc=%0d got=%0d want=%0d", cyc, last_lat, m_last); end
            n_cmp++;
            if (rise_cnt !== m_rise || fall_cnt !== m_fall) begin
                n_bad++; $display("FAIL rnd_counts cyc=%0d rise=%0d fall=%0d want %0d/%0d", cyc, rise_cnt, fall_cnt, m_rise, m_fall);
            end
            n_cmp++;
            if (timeout_err !== m_to || glitch_err !== m_gl) begin
                n_bad++; $display("FAIL rnd_errs cyc=%0d to=%b gl=%b want %b/%b", cyc, timeout_err, glitch_err, m_to, m_gl);
            end
`ifdef AND_TREE_MON_MAXLAT_EN
            n_cmp++;
            if (max_lat !== m_max) begin n_bad++; $display("FAIL rnd_max_lat cyc=%0d got=%0d want=%0d", cyc, max_lat, m_max); end
`endif
        end
    endtask

    initial begin
        rst_n = 0; enable = 0; clear = 0; in_vec = 0; z_async = 0; cyc = 0;
        model_reset();
        #12;
        test_reset();
        test_settle();
        test_latency();
        test_timeout();
        test_glitch();
        test_toggle();
        test_async_reset();
        test_clear_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
